sram_rw_master: RTL and testbench

Single-port request master that drives the RW port (port 0) of the OpenRAM 16x2 SRAM macro. It turns a valid/ready read/write request stream into correctly timed csb0/web0/addr0/din0 strobes, captures dout0 at the correct edge, and returns read data through a 2-entry response buffer with backpressure. An optional power-on init engine writes a fixed value to every word before requests are accepted.

---
 rtl/sram_rw_master.sv | 164 ++++++++++++++++
 tb/tb_sram_rw_master.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_master.sv
// Request master for the RW port of a single-port SRAM macro: registered strobes,
// dout0 capture two edges after acceptance, 2-entry response FIFO, optional init sweep.
module sram_rw_master #(
    parameter int                    DATA_WIDTH = 2,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH:0]   r_init_cnt;
    logic [ADDR_WIDTH:0]   w_init_cnt_nxt;
    logic                  r_csb0;
    logic                  r_web0;
    logic                  w_csb0_nxt;
    logic                  w_web0_nxt;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [ADDR_WIDTH-1:0] w_addr0_nxt;
    logic [DATA_WIDTH-1:0] r_din0;
    logic [DATA_WIDTH-1:0] w_din0_nxt;

    logic [1:0]            r_rd_pipe;
    logic [1:0]            r_credits;
    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_rd_accept;
    logic                  w_push;
    logic                  w_pop;

    // Credits cover reads in flight plus buffered responses, so a push never finds the FIFO full.
    assign w_ready     = (r_state == ST_RUN) && (r_credits < 2'd2) && !rst0;
    assign w_accept    = req_valid && w_ready;
    assign w_rd_accept = w_accept && !req_we;
    assign w_push      = r_rd_pipe[1];
    assign w_pop       = (r_count != 2'd0) && rsp_ready;

    assign req_ready = w_ready;
    assign init_done = (r_state == ST_RUN);
    assign rsp_valid = (r_count != 2'd0);
    assign rsp_rdata = r_fifo[r_rd_ptr];
    assign csb0      = r_csb0;
    assign web0      = r_web0;
    assign addr0     = r_addr0;
    assign din0      = r_din0;

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_csb0_nxt     = 1'b1;
        w_web0_nxt     = 1'b1;
        w_addr0_nxt    = r_addr0;
        w_din0_nxt     = r_din0;
        case (r_state)
            ST_INIT: begin
                // The counter MSB sets once every address has been written.
                if (r_init_cnt[ADDR_WIDTH]) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_csb0_nxt     = 1'b0;
                    w_web0_nxt     = 1'b0;
                    w_addr0_nxt    = r_init_cnt[ADDR_WIDTH-1:0];
                    w_din0_nxt     = INIT_VALUE;
                    w_init_cnt_nxt = r_init_cnt + (ADDR_WIDTH+1)'(1);
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_csb0_nxt  = 1'b0;
                    w_web0_nxt  = !req_we;
                    w_addr0_nxt = req_addr;
                    if (req_we) begin
                        w_din0_nxt = req_wdata;
                    end
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            r_init_cnt <= '0;
            r_csb0     <= 1'b1;
            r_web0     <= 1'b1;
            r_addr0    <= '0;
            r_din0     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_csb0     <= w_csb0_nxt;
            r_web0     <= w_web0_nxt;
            r_addr0    <= w_addr0_nxt;
            r_din0     <= w_din0_nxt;
        end
    end

    // Bit 0: strobes on the bus this cycle; bit 1: dout0 valid at the coming edge.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_rd_pipe <= '0;
            r_credits <= '0;
        end else begin
            r_rd_pipe <= {r_rd_pipe[0], w_rd_accept};
            case ({w_rd_accept, w_pop})
                2'b10:   r_credits <= r_credits + 2'd1;
                2'b01:   r_credits <= r_credits - 2'd1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= dout0;
                r_wr_ptr         <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_rw_master.sv
// Directed bench for sram_rw_master with a behavioural 16x2 SRAM and a read-response scoreboard.
module tb_sram_rw_master;

    logic       clk0 = 1'b0;
    logic       rst0;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [1:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_rdata;
    logic       init_done;
    logic       csb0;
    logic       web0;
    logic [3:0] addr0;
    logic [1:0] din0;
    logic [1:0] dout0;

    logic       b_req_ready;
    logic       b_rsp_valid;
    logic [1:0] b_rsp_rdata;
    logic       b_init_done;
    logic       b_csb0;
    logic       b_web0;
    logic [3:0] b_addr0;
    logic [1:0] b_din0;

    localparam logic [1:0] INIT_VAL = 2'b01;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned n_wr0 = 0;

    logic [1:0] ref_mem [16];
    logic [1:0] q [$];

    always #5 clk0 = ~clk0;

    sram_rw_master #(
        .DATA_WIDTH (2),
        .ADDR_WIDTH (4),
        .INIT_EN    (1),
        .INIT_VALUE (INIT_VAL)
    ) u_dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
    );

    sram_rw_master #(
        .DATA_WIDTH (2),
        .ADDR_WIDTH (4),
        .INIT_EN    (0),
        .INIT_VALUE (INIT_VAL)
    ) u_dut_noinit (
        .clk0      (clk0),
        .rst0      (rst0),
        .req_valid (1'b0),
        .req_ready (b_req_ready),
        .req_we    (1'b0),
        .req_addr  (4'd0),
        .req_wdata (2'd0),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (1'b0),
        .rsp_rdata (b_rsp_rdata),
        .init_done (b_init_done),
        .csb0      (b_csb0),
        .web0      (b_web0),
        .addr0     (b_addr0),
        .din0      (b_din0),
        .dout0     (2'd0)
    );

    // SRAM model: strobes sampled at posedge, write commits and read data appears after negedge.
    logic [1:0] mem [16];
    logic       s_csb;
    logic       s_web;
    logic [3:0] s_addr;
    logic [1:0] s_din;
    initial dout0 = 'x;
    always begin
        @(posedge clk0);
        s_csb  = csb0;
        s_web  = web0;
        s_addr = addr0;
        s_din  = din0;
        #1 dout0 = 'x;
        @(negedge clk0);
        if (!s_csb && !s_web) mem[s_addr] = s_din;
        if (!s_csb && s_web) begin
            #1 dout0 = mem[s_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    // Scoreboard: handshakes seen at negedge are the ones the next posedge will take.
    always @(negedge clk0) begin
        if (rst0) begin
            q.delete();
            for (int i = 0; i < 16; i++) ref_mem[i] = INIT_VAL;
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    logic [1:0] e;
                    e = q.pop_front();
                    chk("rsp_rdata", {30'd0, rsp_rdata}, {30'd0, e});
                end
            end
            if (req_valid && req_ready) begin
                if (req_we) begin
                    ref_mem[req_addr] = req_wdata;
                end else begin
                    q.push_back(ref_mem[req_addr]);
                    chk("credit_bound", {31'd0, (q.size() <= 2)}, 32'd1);
                end
            end
        end
        if (b_csb0 === 1'b0 && b_web0 === 1'b0) n_wr0++;
    end

    task automatic issue(input logic we, input logic [3:0] a, input logic [1:0] d);
        int unsigned w;
        w         = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && w < 40) begin
            tick();
            w++;
        end
        if (w >= 40) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        tick();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        chk("drain", q.size(), 32'd0);
    endtask

    task automatic check_sweep();
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("init_csb0", {31'd0, csb0}, 32'd0);
            chk("init_web0", {31'd0, web0}, 32'd0);
            chk("init_addr0", {28'd0, addr0}, i);
            chk("init_din0", {30'd0, din0}, {30'd0, INIT_VAL});
            chk("init_done_low", {31'd0, init_done}, 32'd0);
            chk("init_ready_low", {31'd0, req_ready}, 32'd0);
            chk("init_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        tick();
        chk("init_done_rise", {31'd0, init_done}, 32'd1);
        chk("ready_rise", {31'd0, req_ready}, 32'd1);
        chk("post_init_csb0", {31'd0, csb0}, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_csb0"}, {31'd0, csb0}, 32'd1);
        chk({tag, "_web0"}, {31'd0, web0}, 32'd1);
        chk({tag, "_addr0"}, {28'd0, addr0}, 32'd0);
        chk({tag, "_din0"}, {30'd0, din0}, 32'd0);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, {30'd0, rsp_rdata}, 32'd0);
        chk({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0      = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");
        chk("noinit_rst_init_done", {31'd0, b_init_done}, 32'd1);
        chk("noinit_rst_ready", {31'd0, b_req_ready}, 32'd0);
        chk("noinit_rst_csb0", {31'd0, b_csb0}, 32'd1);
        chk("noinit_rst_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);

        // Init sweep; the no-init instance must be live from the first cycle.
        rst0 = 1'b0;
        tick();
        chk("noinit_init_done", {31'd0, b_init_done}, 32'd1);
        chk("noinit_ready", {31'd0, b_req_ready}, 32'd1);
        chk("init_csb0_first", {31'd0, csb0}, 32'd0);
        chk("init_addr0_first", {28'd0, addr0}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("init_addr0", {28'd0, addr0}, i);
            chk("init_web0", {31'd0, web0}, 32'd0);
            chk("init_din0", {30'd0, din0}, {30'd0, INIT_VAL});
            chk("init_done_low", {31'd0, init_done}, 32'd0);
            chk("init_ready_low", {31'd0, req_ready}, 32'd0);
        end
        tick();
        chk("init_done_rise", {31'd0, init_done}, 32'd1);
        chk("ready_rise", {31'd0, req_ready}, 32'd1);
        chk("post_init_csb0", {31'd0, csb0}, 32'd1);
        chk("noinit_no_writes", n_wr0, 32'd0);

        // Read back the whole array.
        rsp_ready = 1'b1;
        for (int a = 0; a < 16; a++) issue(1'b0, 4'(a), 2'd0);
        idle();
        drain();

        // Write then read the same address on the next cycle.
        issue(1'b1, 4'd5, 2'b10);
        chk("wr_csb0", {31'd0, csb0}, 32'd0);
        chk("wr_web0", {31'd0, web0}, 32'd0);
        chk("wr_addr0", {28'd0, addr0}, 32'd5);
        chk("wr_din0", {30'd0, din0}, 32'd2);
        issue(1'b0, 4'd5, 2'd0);
        idle();
        chk("rd_csb0", {31'd0, csb0}, 32'd0);
        chk("rd_web0", {31'd0, web0}, 32'd1);
        chk("rd_addr0", {28'd0, addr0}, 32'd5);
        chk("rd_din0_hold", {30'd0, din0}, 32'd2);
        chk("lat_t0_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("idle_csb0", {31'd0, csb0}, 32'd1);
        chk("idle_addr0_hold", {28'd0, addr0}, 32'd5);
        chk("lat_t1_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("lat_t2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("lat_t2_rdata", {30'd0, rsp_rdata}, 32'd2);
        drain();

        // Backpressure: four reads with the consumer stalled.
        issue(1'b1, 4'd3, 2'd0);
        issue(1'b1, 4'd4, 2'd1);
        issue(1'b1, 4'd5, 2'd2);
        issue(1'b1, 4'd6, 2'd3);
        idle();
        rsp_ready = 1'b0;
        issue(1'b0, 4'd3, 2'd0);
        issue(1'b0, 4'd4, 2'd0);
        chk("bp_ready_drop", {31'd0, req_ready}, 32'd0);
        req_addr = 4'd5;
        tick();
        tick();
        tick();
        chk("bp_ready_held", {31'd0, req_ready}, 32'd0);
        chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_head", {30'd0, rsp_rdata}, 32'd0);
        rsp_ready = 1'b1;
        issue(1'b0, 4'd5, 2'd0);
        issue(1'b0, 4'd6, 2'd0);
        idle();
        drain();

        // Pop and read acceptance in the same cycle with one credit held.
        rsp_ready = 1'b0;
        issue(1'b0, 4'd9, 2'd0);
        idle();
        tick();
        tick();
        tick();
        chk("c1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("c1_ready", {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd10;
        tick();
        rsp_ready = 1'b0;
        req_addr  = 4'd11;
        chk("c1_ready_after_swap", {31'd0, req_ready}, 32'd1);
        chk("c1_fifo_empty", {31'd0, rsp_valid}, 32'd0);
        tick();
        idle();
        chk("c2_ready_drop", {31'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        drain();

        // Reset with one response buffered and one read in flight.
        rsp_ready = 1'b0;
        issue(1'b0, 4'd7, 2'd0);
        idle();
        tick();
        issue(1'b0, 4'd8, 2'd0);
        idle();
        rst0      = 1'b1;
        rsp_ready = 1'b1;
        tick();
        check_reset_vals("midrst");
        rst0 = 1'b0;
        check_sweep();
        tick();
        tick();
        chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // The sweep rewrote address 5.
        issue(1'b0, 4'd5, 2'd0);
        issue(1'b0, 4'd8, 2'd0);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
